console_text_buffer: RTL and testbench

CONSOLE_TEXT_BUFFER -- requirements
Module: console_text_buffer

---
 rtl/console_text_buffer.sv | 190 +++++++++++++++++++
 tb/tb_console_text_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_text_buffer.sv
// Character-cell text buffer: accepts a console byte stream and serves {codepoint, attribute}
// to the renderer from pixel coordinates. Optional cursor blink: define TEXT_BUFFER_CURSOR_EN.
module console_text_buffer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter logic [7:0] BLANK_ATTR = 8'h0F
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  input  logic [7:0] char_attr,
  output logic       char_ready,
  output logic [7:0] codepoint,
  output logic [7:0] attribute,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row
);
  localparam int              CELLS      = COLS * ROWS;
  localparam int              AW         = $clog2(CELLS);
  localparam logic [15:0]     BLANK_CELL = {8'h20, BLANK_ATTR};
  localparam logic [AW-1:0]   LAST_CELL  = AW'(CELLS - 1);
  localparam logic [AW-1:0]   LAST_COL   = AW'(COLS - 1);
  localparam logic [6:0]      COL_MAX    = 7'(COLS - 1);
  localparam logic [4:0]      ROW_MAX    = 5'(ROWS - 1);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] clr_cnt_reg, clr_cnt_next;
  logic [AW-1:0] clr_base_reg, clr_base_next;
  logic [6:0]    col_reg, col_next;
  logic [4:0]    row_reg, row_next;
  logic [4:0]    top_reg, top_next;
  logic          line_feed;

  logic [15:0]   mem [CELLS];
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_q;
  logic          oob, oob_reg;
  logic [7:0]    attr_eff;
  logic [4:0]    disp_row;

  // Sum of two rows, each below ROWS, folded back into 0..ROWS-1.
  function automatic logic [4:0] wrap_row(input logic [5:0] r);
    return (r >= 6'(ROWS)) ? 5'(r - 6'(ROWS)) : r[4:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  always_comb begin
    state_next    = state_reg;
    clr_cnt_next  = clr_cnt_reg;
    clr_base_next = clr_base_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    top_next      = top_reg;
    line_feed     = 1'b0;
    we            = 1'b0;
    wr_addr       = cell_addr(wrap_row({1'b0, row_reg} + {1'b0, top_reg}), col_reg);
    wr_data       = {char_data, char_attr};
    case (state_reg)
      CLEAR_ALL: begin
        we           = 1'b1;
        wr_addr      = clr_cnt_reg;
        wr_data      = BLANK_CELL;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == LAST_CELL) begin
          clr_cnt_next = '0;
          state_next   = IDLE;
        end
      end
      CLEAR_LINE: begin
        we           = 1'b1;
        wr_addr      = clr_base_reg + clr_cnt_reg;
        wr_data      = BLANK_CELL;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == LAST_COL) begin
          clr_cnt_next = '0;
          state_next   = IDLE;
        end
      end
      IDLE: begin
        if (char_valid) begin
          if (char_data >= 8'h20) begin
            we = 1'b1;
            if (col_reg == COL_MAX) begin
              col_next  = '0;
              line_feed = 1'b1;
            end else begin
              col_next = col_reg + 7'd1;
            end
          end else begin
            case (char_data)
              8'h0A: begin
                col_next  = '0;
                line_feed = 1'b1;
              end
              8'h0D: col_next = '0;
              8'h08: if (col_reg != '0) col_next = col_reg - 7'd1;
              default: ;
            endcase
          end
          // At the bottom the view scrolls: the old top line becomes the new bottom line.
          if (line_feed) begin
            if (row_reg != ROW_MAX) begin
              row_next = row_reg + 5'd1;
            end else begin
              top_next      = wrap_row({1'b0, top_reg} + 6'd1);
              clr_base_next = cell_addr(top_reg, 7'd0);
              state_next    = CLEAR_LINE;
            end
          end
        end
      end
      default: state_next = CLEAR_ALL;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= CLEAR_ALL;
      clr_cnt_reg  <= '0;
      clr_base_reg <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      top_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      clr_base_reg <= clr_base_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      top_reg      <= top_next;
    end
  end

  assign oob      = (cx >= 10'(COLS * 8)) || (cy >= 10'(ROWS * 16));
  assign disp_row = wrap_row({1'b0, cy[8:4]} + {1'b0, top_reg});
  assign rd_addr  = oob ? '0 : cell_addr(disp_row, cx[9:3]);

  // Unreset RAM; the read sees pre-write contents on a same-cell collision.
  always_ff @(posedge clk_pixel) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end

`ifdef TEXT_BUFFER_CURSOR_EN
  logic [5:0] frame_cnt_reg;
  logic       cur_hit_reg;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg <= '0;
      cur_hit_reg   <= 1'b0;
    end else begin
      if (cx == '0 && cy == '0) frame_cnt_reg <= frame_cnt_reg + 6'd1;
      cur_hit_reg <= (cx[9:3] == col_reg) && (cy[8:4] == row_reg);
    end
  end

  assign attr_eff = (frame_cnt_reg[5] && cur_hit_reg) ? ~rd_q[7:0] : rd_q[7:0];
`else
  assign attr_eff = rd_q[7:0];
`endif

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      oob_reg   <= 1'b1;
      codepoint <= 8'h20;
      attribute <= BLANK_ATTR;
    end else begin
      oob_reg   <= oob;
      codepoint <= oob_reg ? 8'h20 : rd_q[15:8];
      attribute <= oob_reg ? BLANK_ATTR : attr_eff;
    end
  end

  assign char_ready = (state_reg == IDLE);
  assign cursor_col = col_reg;
  assign cursor_row = row_reg;

endmodule

// File: tb/tb_console_text_buffer.sv
// Bench for console_text_buffer: table-driven character stream against a shifting-screen
// model, with cell reads scored through a latency-tagged queue.
module tb_console_text_buffer;
  localparam int          COLS  = 80;
  localparam int          ROWS  = 30;
  localparam logic [15:0] BLANK = 16'h200F;

  logic       clk_pixel = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] cx = 10'h3FF;
  logic [9:0] cy = 10'h3FF;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic [7:0] char_attr = 8'h00;
  logic       char_ready;
  logic [7:0] codepoint, attribute;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  always #5 clk_pixel = ~clk_pixel;

  console_text_buffer dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .cx        (cx),
    .cy        (cy),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_attr (char_attr),
    .char_ready(char_ready),
    .codepoint (codepoint),
    .attribute (attribute),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row)
  );

  typedef struct {
    int          due;
    logic [15:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    logic [7:0] d;
    logic [7:0] a;
    int         col;
    int         row;
  } vec_t;

  sb_t         sb_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          fc = 0;
  int          mcol = 0;
  int          mrow = 0;
  logic [15:0] scr [ROWS][COLS];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (!reset_n) fc = 0;
    else if (cx == 10'd0 && cy == 10'd0) fc++;
    @(posedge clk_pixel);
    #1;
    cyc++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_t e;
      e = sb_q.pop_front();
      chk(e.name, int'({codepoint, attribute}), int'(e.exp));
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = BLANK;
    mcol = 0;
    mrow = 0;
    sb_q.delete();
  endtask

  // Reference screen kept in logical order; a scroll physically shifts every row up.
  task automatic model_char(input logic [7:0] d, input logic [7:0] a);
    bit lf;
    lf = 1'b0;
    if (d >= 8'h20) begin
      scr[mrow][mcol] = {d, a};
      if (mcol == COLS - 1) begin
        mcol = 0;
        lf = 1'b1;
      end else mcol++;
    end else if (d == 8'h0A) begin
      mcol = 0;
      lf = 1'b1;
    end else if (d == 8'h0D) mcol = 0;
    else if (d == 8'h08 && mcol > 0) mcol--;
    if (lf) begin
      if (mrow < ROWS - 1) mrow++;
      else begin
        for (int r = 0; r < ROWS - 1; r++)
          for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = BLANK;
      end
    end
  endtask

  task automatic issue(input int x, input int y, input logic [15:0] exp, input string name);
    cx = 10'(x);
    cy = 10'(y);
    sb_q.push_back('{cyc + 2, exp, name});
    tick();
  endtask

  task automatic drain();
    cx = 10'h3FF;
    cy = 10'h3FF;
    repeat (3) tick();
  endtask

  task automatic scan();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        issue(c * 8 + int'($urandom_range(0, 7)), r * 16 + int'($urandom_range(0, 15)),
              scr[r][c], $sformatf("cell_%0d_%0d", c, r));
    drain();
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    int w;
    w = 0;
    char_data  = d;
    char_attr  = a;
    char_valid = 1'b1;
    while (!char_ready && w < 3000) begin
      tick();
      w++;
    end
    if (!char_ready) chk("send_ready_timeout", int'(char_ready), 1);
    else begin
      tick();
      model_char(d, a);
    end
    char_valid = 1'b0;
  endtask

  task automatic wait_ready(input int exp, input string name);
    int cnt;
    cnt = 0;
    while (!char_ready && cnt < 3000) begin
      tick();
      cnt++;
    end
    chk(name, cnt, exp);
  endtask

  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    #2;
    chk("rst_ready", int'(char_ready), 0);
    chk("rst_cell", int'({codepoint, attribute}), int'(BLANK));
    chk("rst_col", int'(cursor_col), 0);
    chk("rst_row", int'(cursor_row), 0);
    repeat (hold) tick();
    reset_n = 1'b1;
    model_reset();
    wait_ready(COLS * ROWS, "clear_all_cycles");
  endtask

  initial begin
    vec_t tbl[14];
    int   w;
    tbl = '{
      '{8'h43, 8'h3A, 2, 0}, '{8'h44, 8'h3B, 3, 0}, '{8'h45, 8'h3C, 4, 0},
      '{8'h46, 8'h3D, 5, 0}, '{8'h0D, 8'h00, 0, 0}, '{8'h08, 8'h00, 0, 0},
      '{8'h07, 8'h11, 0, 0}, '{8'h0A, 8'h00, 0, 1}, '{8'h7E, 8'h55, 1, 1},
      '{8'h0A, 8'h00, 0, 2}, '{8'h1F, 8'h22, 0, 2}, '{8'h20, 8'h70, 1, 2},
      '{8'hFF, 8'h81, 2, 2}, '{8'h08, 8'h00, 1, 2}
    };
    model_reset();
    #1;
    do_reset(1);
    scan();

    send(8'h41, 8'h1E);
    chk("a_col", int'(cursor_col), 1);
    issue(0, 0, 16'h411E, "a_cell");
    drain();

    for (int i = 0; i < 14; i++) begin
      send(tbl[i].d, tbl[i].a);
      chk($sformatf("vec%0d_col", i), int'(cursor_col), tbl[i].col);
      chk($sformatf("vec%0d_row", i), int'(cursor_row), tbl[i].row);
    end

    char_data = 8'h41;
    repeat (3) tick();
    chk("idle_col", int'(cursor_col), 1);
    chk("idle_row", int'(cursor_row), 2);

    send(8'h0A, 8'h00);
    for (int i = 0; i < COLS; i++) send(8'(8'h21 + i), 8'(i));
    chk("wrap_col", int'(cursor_col), 0);
    chk("wrap_row", int'(cursor_row), 4);
    issue(79 * 8, 3 * 16, 16'h704F, "wrap_last_cell");
    drain();
    scan();

    for (int i = 0; i < 25; i++) send(8'h0A, 8'h00);
    chk("bottom_row", int'(cursor_row), ROWS - 1);
    send(8'h5A, 8'h44);
    send(8'h0A, 8'h00);
    wait_ready(COLS, "scroll_busy");
    chk("scroll_col", int'(cursor_col), 0);
    chk("scroll_row", int'(cursor_row), ROWS - 1);
    issue(0, 0, 16'h7E55, "scroll_top");
    issue(0, 448, 16'h5A44, "scroll_row28");
    issue(0, 464, BLANK, "scroll_bottom");
    issue(640, 0, BLANK, "oob_x");
    issue(0, 480, BLANK, "oob_y");
    issue(1023, 1023, BLANK, "oob_max");
    issue(639, 479, scr[ROWS-1][COLS-1], "edge_cell");
    drain();
    scan();

    send(8'h0A, 8'h00);
    repeat (10) tick();
    do_reset(2);
    issue(0, 0, BLANK, "post_rst_top");
    issue(0, 464, BLANK, "post_rst_bottom");
    drain();

    chk("sc_ready", int'(char_ready), 1);
    cx = 10'd0;
    cy = 10'd0;
    char_data  = 8'h51;
    char_attr  = 8'h3C;
    char_valid = 1'b1;
    sb_q.push_back('{cyc + 2, BLANK, "same_cell_old"});
    tick();
    char_valid = 1'b0;
    model_char(8'h51, 8'h3C);
    sb_q.push_back('{cyc + 2, 16'h513C, "same_cell_new"});
    tick();
    drain();

`ifdef TEXT_BUFFER_CURSOR_EN
    send(8'h0D, 8'h00);
    send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    send(8'h61, 8'h12);
    send(8'h62, 8'h12);
    send(8'h63, 8'h12);
    chk("cur_col", int'(cursor_col), 3);
    chk("cur_row", int'(cursor_row), 2);
    cx = 10'd0;
    cy = 10'd0;
    w = 0;
    while ((fc % 64) < 40 && w < 200) begin
      tick();
      w++;
    end
    issue(24, 32, 16'h20F0, "cursor_inverted");
    issue(16, 32, 16'h6312, "cursor_neighbour");
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
